// File: rtl/pc_call_stack.sv
// pc_call_stack: Hack CPU program counter with stall enable, call/return and
// an on-chip return-address stack (RAS). out drives the instruction ROM address.
module pc_call_stack #(
    parameter  int WIDTH    = 15,
    parameter  int DEPTH    = 8,
    parameter  bit OVF_WRAP = 1'b0,
    localparam int DW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty,
    output logic             stack_err
);

    localparam int             PW      = $clog2(DEPTH);
    localparam logic [DW-1:0]  DEPTH_V = DW'(DEPTH);
    localparam logic [PW-1:0]  TOP_MAX = PW'(DEPTH - 1);

    logic [WIDTH-1:0] ras [DEPTH];
    logic [PW-1:0]    top;        // next free slot; top-1 is the most recent entry
    logic [DW-1:0]    cnt;
    logic [WIDTH-1:0] pc_inc;
    logic [PW-1:0]    ptr_up;
    logic [PW-1:0]    ptr_dn;
    logic             do_push;

    // Pointer arithmetic is modulo DEPTH, which need not be a power of two.
    always_comb begin
        pc_inc  = out + WIDTH'(1);
        ptr_up  = (top == TOP_MAX) ? '0 : top + PW'(1);
        ptr_dn  = (top == '0) ? TOP_MAX : top - PW'(1);
        depth   = cnt;
        full    = (cnt == DEPTH_V);
        empty   = (cnt == '0);
        // A tail call (ret&call) never touches the stack; a full stack only
        // accepts the push when it is allowed to overwrite the oldest entry.
        do_push = en && call && !ret && (!full || OVF_WRAP);
    end

    // RAS storage: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (reset && do_push)
            ras[top] <= pc_inc;
    end

    // PC, stack pointer, depth and sticky error update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out       <= '0;
            top       <= '0;
            cnt       <= '0;
            stack_err <= 1'b0;
        end else if (en) begin
            if (ret && call) begin
                out <= in;
            end else if (ret) begin
                if (!empty) begin
                    out <= ras[ptr_dn];
                    top <= ptr_dn;
                    cnt <= cnt - DW'(1);
                end else begin
                    out       <= pc_inc;
                    stack_err <= 1'b1;
                end
            end else if (call) begin
                out <= in;
                if (!full) begin
                    top <= ptr_up;
                    cnt <= cnt + DW'(1);
                end else if (OVF_WRAP) begin
                    top <= ptr_up;  // overwrite oldest, depth stays at DEPTH
                end else begin
                    stack_err <= 1'b1;
                end
            end else if (load) begin
                out <= in;
            end else begin
                out <= pc_inc;
            end
        end
    end

endmodule

// File: tb/tb_pc_call_stack.sv
// tb_pc_call_stack: directed stimulus against two instances (drop / wrap on
// overflow) sharing inputs; expectations come from a queue-based stack model.
module tb_pc_call_stack;

    logic        clk = 1'b0;
    logic        reset, en, load, call, ret;
    logic [14:0] in;
    logic [14:0] out0, out1;
    logic [3:0]  dep0, dep1;
    logic        full0, full1, empty0, empty1, err0, err1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [14:0] pc;
        logic [3:0]  dep;
        logic        full;
        logic        empty;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    logic [14:0] stk0[$], stk1[$];
    logic [14:0] mpc[2];
    logic        merr[2];

    always #5 clk = ~clk;

    pc_call_stack #(.WIDTH(15), .DEPTH(8), .OVF_WRAP(1'b0)) u_drop (
        .clk(clk), .reset(reset), .en(en), .load(load), .call(call), .ret(ret),
        .in(in), .out(out0), .depth(dep0), .full(full0), .empty(empty0), .stack_err(err0)
    );

    pc_call_stack #(.WIDTH(15), .DEPTH(8), .OVF_WRAP(1'b1)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .load(load), .call(call), .ret(ret),
        .in(in), .out(out1), .depth(dep1), .full(full1), .empty(empty1), .stack_err(err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one instance; k=1 overwrites the oldest entry on overflow.
    task automatic model(input int k);
        logic [14:0] q[$];
        logic [14:0] pc;
        exp_t        e;
        q  = (k == 0) ? stk0 : stk1;
        pc = mpc[k];
        if (!reset) begin
            pc = '0;
            q  = {};
            merr[k] = 1'b0;
        end else if (en) begin
            if (ret && call) begin
                pc = in;
            end else if (ret) begin
                if (q.size() > 0) pc = q.pop_back();
                else begin
                    pc = pc + 15'd1;
                    merr[k] = 1'b1;
                end
            end else if (call) begin
                if (q.size() < 8) q.push_back(pc + 15'd1);
                else if (k == 1) begin
                    void'(q.pop_front());
                    q.push_back(pc + 15'd1);
                end else merr[k] = 1'b1;
                pc = in;
            end else if (load) begin
                pc = in;
            end else begin
                pc = pc + 15'd1;
            end
        end
        mpc[k] = pc;
        if (k == 0) stk0 = q; else stk1 = q;
        e.pc    = pc;
        e.dep   = 4'(q.size());
        e.full  = (q.size() == 8);
        e.empty = (q.size() == 0);
        e.err   = merr[k];
        sbq.push_back(e);
    endtask

    // Drive one cycle, queue expectations, then compare both instances after the edge.
    task automatic step(input string tag, input logic r, input logic e_, input logic l,
                        input logic c, input logic rt, input logic [14:0] d);
        exp_t x;
        @(negedge clk);
        reset = r; en = e_; load = l; call = c; ret = rt; in = d;
        model(0);
        model(1);
        @(posedge clk);
        #1;
        x = sbq.pop_front();
        check({tag, "/drop.out"},   32'(out0),   32'(x.pc));
        check({tag, "/drop.depth"}, 32'(dep0),   32'(x.dep));
        check({tag, "/drop.full"},  32'(full0),  32'(x.full));
        check({tag, "/drop.empty"}, 32'(empty0), 32'(x.empty));
        check({tag, "/drop.err"},   32'(err0),   32'(x.err));
        x = sbq.pop_front();
        check({tag, "/wrap.out"},   32'(out1),   32'(x.pc));
        check({tag, "/wrap.depth"}, 32'(dep1),   32'(x.dep));
        check({tag, "/wrap.full"},  32'(full1),  32'(x.full));
        check({tag, "/wrap.empty"}, 32'(empty1), 32'(x.empty));
        check({tag, "/wrap.err"},   32'(err1),   32'(x.err));
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0; in = '0;
        mpc[0] = '0; mpc[1] = '0; merr[0] = 1'b0; merr[1] = 1'b0;

        // reset then free-run from 0
        step("rst0", 0, 0, 0, 0, 0, 15'h0);
        step("rst1", 0, 1, 1, 1, 0, 15'h1234);
        for (int i = 0; i < 5; i++) step("inc", 1, 1, 0, 0, 0, 15'h0);
        check("t1.pc_is_5", 32'(out0), 32'd5);

        // wrap of the PC past all-ones
        step("ld7ffe", 1, 1, 1, 0, 0, 15'h7FFE);
        step("to7fff", 1, 1, 0, 0, 0, 15'h0);
        step("to0000", 1, 1, 0, 0, 0, 15'h0);
        check("t2.pc_wrapped", 32'(out0), 32'd0);

        // call / increments / return
        step("ld0010", 1, 1, 1, 0, 0, 15'h0010);
        step("call200", 1, 1, 1, 1, 0, 15'h0200);
        for (int i = 0; i < 3; i++) step("sub_inc", 1, 1, 0, 0, 0, 15'h0);
        check("t3.pc_0203", 32'(out0), 32'h0203);
        step("ret", 1, 1, 1, 0, 1, 15'h7777);
        check("t3.ret_0011", 32'(out0), 32'h0011);

        // nine calls with a gap between each: overflow on the ninth
        for (int i = 0; i < 9; i++) begin
            step("call_n", 1, 1, 0, 1, 0, 15'(16'h0100 * (i + 1)));
            step("gap", 1, 1, 0, 0, 0, 15'h0);
        end
        step("tail_full", 1, 1, 0, 1, 1, 15'h4444);
        step("ld_full", 1, 1, 1, 0, 0, 15'h0040);
        for (int i = 0; i < 8; i++) step("ret_n", 1, 1, 0, 0, 1, 15'h0);
        step("tail_empty", 1, 1, 0, 1, 1, 15'h2222);
        check("t5.wrap_no_err", 32'(err1), 32'd0);

        // stall holds everything, even a call and a ret on empty
        step("stall_call", 1, 0, 0, 1, 0, 15'h3333);
        step("stall_ret", 1, 0, 0, 0, 1, 15'h0);
        step("ret_empty", 1, 1, 0, 0, 1, 15'h0);
        check("t6.wrap_err_set", 32'(err1), 32'd1);
        step("sticky", 1, 1, 0, 0, 0, 15'h0);
        step("call_pre_rst", 1, 1, 0, 1, 0, 15'h0500);
        step("rst_mid", 0, 1, 0, 1, 0, 15'h0600);
        step("post_rst", 1, 1, 0, 0, 1, 15'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
